// File: rtl/instr_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_responder_pkg -- shared instruction types, constants and FSM enum
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instr_mem_responder_pkg;

  typedef logic [31:0] arch_reg;

  localparam arch_reg NOP_INSTR = 32'h00000013;
  localparam arch_reg RESET_PC  = 32'h01000000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } imem_state_e;

  // States in which the backing memory sees an outstanding read.
  function automatic logic is_mem_state(input imem_state_e s);
    return (s == REQ) || (s == DRAIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder_addr_decode.sv
// ----------------------------------------------------------------------------
// imem_addr_decode -- instruction-window check and word-index extraction
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_addr_decode
  import instr_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int          MEM_WORDS = 4096
) (
  input  arch_reg                        pc,
  output logic                           in_window,
  output logic [$clog2(MEM_WORDS)-1:0]   index
);

  localparam int          AW     = $clog2(MEM_WORDS);
  // One extra bit keeps the window end from wrapping near the top of memory.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(MEM_WORDS) << 2);

  logic [32:0] pc_ext;
  logic        aligned;

  always_comb begin
    pc_ext    = {1'b0, pc};
    aligned   = (pc[1:0] == 2'b00);
    in_window = aligned && (pc_ext >= WIN_LO) && (pc_ext < WIN_HI);
    index     = AW'((pc - BASE_ADDR) >> 2);
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder -- fetch-side responder in front of a word memory
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int          MEM_WORDS = 4096,
  parameter int          TIMEOUT   = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  arch_reg                      PC_in,
  input  logic                         stall_in,
  input  logic                         flush,
  output arch_reg                      data_out,
  output logic                         data_valid,
  output logic                         fault,
  output logic                         mem_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_ack
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(TIMEOUT + 1);

  imem_state_e   state;
  imem_state_e   state_nxt;
  logic [CW-1:0] count;
  logic          timeout_hit;
  logic          pc_ok;
  logic [AW-1:0] pc_index;

  arch_reg       data_nxt;
  logic          valid_nxt;
  logic          fault_nxt;
  logic          en_nxt;

  imem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_decode (
    .pc        (PC_in),
    .in_window (pc_ok),
    .index     (pc_index)
  );

  assign timeout_hit = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush)      state_nxt = IDLE;
        else if (pc_ok) state_nxt = REQ;
        else            state_nxt = FAULT;
      end
      // flush outranks ack; an un-acked flush must still retire the read.
      REQ: begin
        if (flush)            state_nxt = mem_ack ? IDLE : DRAIN;
        else if (mem_ack)     state_nxt = HOLD;
        else if (timeout_hit) state_nxt = FAULT;
        else                  state_nxt = REQ;
      end
      HOLD, FAULT: begin
        if (flush || !stall_in) state_nxt = IDLE;
      end
      DRAIN: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = (state_nxt == HOLD) || (state_nxt == FAULT);
    fault_nxt = (state_nxt == FAULT);
    en_nxt    = is_mem_state(state_nxt);
    data_nxt  = NOP_INSTR;
    if (state_nxt == HOLD) begin
      data_nxt = (state == REQ) ? mem_rdata : data_out;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out   <= NOP_INSTR;
      data_valid <= 1'b0;
      fault      <= 1'b0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      count      <= '0;
    end else begin
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
      fault      <= fault_nxt;
      mem_en     <= en_nxt;
      if (state == IDLE && state_nxt == REQ) begin
        mem_addr <= pc_index;
      end
      count <= (state == REQ && state_nxt == REQ) ? count + CW'(1) : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_responder -- vector table, corner sequences and random fetches
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_responder;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int          WORDS = 4096;
  localparam int          TMO   = 15;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clock;
  logic        reset;
  logic [31:0] PC_in;
  logic        stall_in;
  logic        flush;
  logic [31:0] data_out;
  logic        data_valid;
  logic        fault;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] rdata;
    int          stall;
    logic        exp_req;
    logic        exp_fault;
    logic [31:0] exp_data;
    logic [11:0] exp_addr;
    int          exp_cyc;
  } vec_t;

  instr_mem_responder #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS),
    .TIMEOUT   (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .PC_in      (PC_in),
    .stall_in   (stall_in),
    .flush      (flush),
    .data_out   (data_out),
    .data_valid (data_valid),
    .fault      (fault),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Transaction-level expectation straight from the address/timeout rules.
  function automatic vec_t model(input logic [31:0] pc, input int lat,
                                 input logic [31:0] rdata, input int stall);
    vec_t v;
    logic [32:0] p   = {1'b0, pc};
    logic [32:0] lo  = {1'b0, BASE};
    logic [32:0] hi  = lo + 33'(4 * WORDS);
    logic        win = (pc % 4 == 0) && (p >= lo) && (p < hi);
    logic [31:0] off = pc - BASE;
    v.pc        = pc;
    v.lat       = lat;
    v.rdata     = rdata;
    v.stall     = stall;
    v.exp_req   = win;
    v.exp_fault = !win || (lat >= TMO);
    v.exp_data  = v.exp_fault ? NOP : rdata;
    v.exp_addr  = 12'(off / 4);
    v.exp_cyc   = !win ? 0 : ((lat >= TMO) ? TMO : lat + 1);
    return v;
  endfunction

  // Starts in IDLE, ends in IDLE after the word is consumed.
  task automatic run_fetch(input vec_t v);
    int          cyc;
    logic        stable;
    logic [31:0] held;
    PC_in    = v.pc;
    flush    = 1'b0;
    stall_in = 1'b1;
    mem_ack  = 1'b0;
    step();
    chk("first_mem_en", 32'(mem_en), 32'(v.exp_req));
    if (v.exp_req) begin
      chk("req_mem_addr", 32'(mem_addr), 32'(v.exp_addr));
      chk("req_not_valid", 32'(data_valid), 32'd0);
      cyc    = 0;
      stable = 1'b1;
      while (!data_valid && cyc < 40) begin
        if (!mem_en || mem_addr !== v.exp_addr) stable = 1'b0;
        mem_ack   = mem_en && (cyc == v.lat);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        step();
        cyc++;
      end
      mem_ack = 1'b0;
      chk("req_en_addr_stable", 32'(stable), 32'd1);
      chk("latency_cycles", 32'(cyc), 32'(v.exp_cyc));
    end
    chk("resp_valid", 32'(data_valid), 32'd1);
    chk("resp_fault", 32'(fault), 32'(v.exp_fault));
    chk("resp_data", data_out, v.exp_data);
    chk("resp_mem_en_low", 32'(mem_en), 32'd0);
    if (v.stall > 0) begin
      held   = data_out;
      stable = 1'b1;
      for (int i = 0; i < v.stall; i++) begin
        mem_rdata = $urandom;
        step();
        if (data_out !== held || !data_valid) stable = 1'b0;
      end
      chk("stall_hold", 32'(stable), 32'd1);
    end
    stall_in = 1'b0;
    step();
    chk("consumed_valid", 32'(data_valid), 32'd0);
    chk("consumed_data", data_out, NOP);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{32'h01000000,  2, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'hDEADBEEF, 12'd0,    3};
    tbl[1] = '{32'h01000002,  0, 32'h0,        0, 1'b0, 1'b1, NOP,          12'd0,    0};
    tbl[2] = '{32'h01004000,  0, 32'h0,        0, 1'b0, 1'b1, NOP,          12'd0,    0};
    tbl[3] = '{32'h01003FFC,  0, 32'hCAFEF00D, 0, 1'b1, 1'b0, 32'hCAFEF00D, 12'd4095, 1};
    tbl[4] = '{32'h00FFFFFC,  0, 32'h0,        1, 1'b0, 1'b1, NOP,          12'd0,    0};
    tbl[5] = '{32'h01000004, 15, 32'h0,        0, 1'b1, 1'b1, NOP,          12'd1,   15};
    tbl[6] = '{32'h01000010, 14, 32'hA5A5A5A5, 0, 1'b1, 1'b0, 32'hA5A5A5A5, 12'd4,   15};
    tbl[7] = '{32'hFFFFFFFC,  0, 32'h0,        0, 1'b0, 1'b1, NOP,          12'd0,    0};
    tbl[8] = '{32'h01000ABC,  1, 32'h13579BDF, 5, 1'b1, 1'b0, 32'h13579BDF, 12'h2AF,  2};
    tbl[9] = '{32'h01000001,  0, 32'h0,        2, 1'b0, 1'b1, NOP,          12'd0,    0};

    reset     = 1'b0;
    PC_in     = 32'h01000008;
    stall_in  = 1'b1;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) step();
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", data_out, NOP);

    // Release between edges: nothing may move until the next posedge.
    reset = 1'b1;
    #2;
    chk("rel_no_early_en", 32'(mem_en), 32'd0);
    @(posedge clock); #1;
    chk("rel_req_en", 32'(mem_en), 32'd1);
    chk("rel_req_addr", 32'(mem_addr), 32'd2);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    chk("rel_data", data_out, 32'h11111111);
    stall_in = 1'b0;
    step();

    foreach (tbl[i]) run_fetch(tbl[i]);

    // flush in REQ, ack three cycles later while draining
    PC_in = 32'h01000020; stall_in = 1'b1;
    step();
    flush = 1'b1;
    step();
    chk("drain_en", 32'(mem_en), 32'd1);
    chk("drain_valid", 32'(data_valid), 32'd0);
    step();
    flush = 1'b0;
    step();
    chk("drain_en_held", 32'(mem_en), 32'd1);
    chk("drain_valid_held", 32'(data_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("drain_done_en", 32'(mem_en), 32'd0);
    chk("drain_done_valid", 32'(data_valid), 32'd0);
    chk("drain_done_data", data_out, NOP);

    // flush coincident with ack in REQ
    PC_in = 32'h01000030;
    step();
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    step();
    flush = 1'b0; mem_ack = 1'b0;
    chk("flush_ack_en", 32'(mem_en), 32'd0);
    chk("flush_ack_valid", 32'(data_valid), 32'd0);
    chk("flush_ack_data", data_out, NOP);

    // flush in HOLD and in FAULT
    PC_in = 32'h01000050;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0F0F0F0F;
    step();
    mem_ack = 1'b0; flush = 1'b1;
    step();
    chk("flush_hold_valid", 32'(data_valid), 32'd0);
    flush = 1'b0; PC_in = 32'h01000051;
    step();
    chk("fault_entry", 32'(fault), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_fault_valid", 32'(data_valid), 32'd0);
    chk("flush_fault_flag", 32'(fault), 32'd0);

    // asynchronous reset while a read is outstanding
    PC_in = 32'h01000040;
    step();
    chk("mid_req_en", 32'(mem_en), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(mem_en), 32'd0);
    chk("async_rst_data", data_out, NOP);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    step();
    reset = 1'b1;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      int          lat;
      case ($urandom_range(0, 4))
        0, 1:    pc = BASE + 4 * $urandom_range(0, WORDS - 1);
        2:       pc = (BASE + $urandom_range(0, 4 * WORDS - 1)) | 32'($urandom_range(1, 3));
        3:       pc = $urandom_range(0, BASE - 1);
        default: pc = BASE + 32'(4 * WORDS) + $urandom_range(0, 32'h000FFFFF);
      endcase
      lat = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 5);
      run_fetch(model(pc, lat, $urandom, $urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h01000000, SHALL be the byte address of instruction word 0.
REQ-002 Parameter MEM_WORDS, default 4096, SHALL be the number of 32-bit words in the window.
REQ-003 Parameter TIMEOUT, default 15, SHALL be the maximum number of REQ cycles to wait for mem_ack.
REQ-004 The ports SHALL be:
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low.
- PC_in  in  32 (arch_reg)  fetch address.
- stall_in  in  1  fetch is holding its PC; the returned word is not consumed.
- flush  in  1  fetch redirect; abandon the current access.
- data_out  out  32 (arch_reg)  instruction word to fetch.
- data_valid  out  1  data_out/fault valid for PC_in.
- fault  out  1  access error for the current word.
- mem_en  out  1  backing-memory read request.
- mem_addr  out  $clog2(MEM_WORDS)  word index.
- mem_rdata  in  32  backing-memory read data.
- mem_ack  in  1  mem_rdata valid; legal only while mem_en=1.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, REQ, HOLD, DRAIN and FAULT.
REQ-006 In IDLE, an in-window, word-aligned PC_in SHALL cause REQ next cycle. mem_addr SHALL be latched as (PC_in-BASE_ADDR)>>2.
REQ-007 In IDLE, PC_in[1:0]!=0, PC_in<BASE_ADDR, or PC_in>=BASE_ADDR+4*MEM_WORDS SHALL cause FAULT next cycle, with no mem_en.
REQ-008 The window comparison SHALL use 33-bit arithmetic so that BASE_ADDR+4*MEM_WORDS does not wrap.
REQ-009 mem_en SHALL be 1 exactly in states REQ and DRAIN. mem_addr SHALL be stable throughout.
REQ-010 In REQ with mem_ack=1 and flush=0, mem_rdata SHALL be registered into data_out and the state SHALL go to HOLD.
REQ-011 In HOLD, data_valid=1 and fault=0. stall_in=0 SHALL consume the word and move to IDLE. stall_in=1 SHALL keep HOLD with data_out unchanged.
REQ-012 In FAULT, data_valid=1, fault=1 and data_out=32'h00000013 (NOP). Consumption SHALL follow REQ-011.
REQ-013 A cycle counter SHALL clear on REQ entry and increment each REQ cycle without ack. On reaching TIMEOUT, the state SHALL go to FAULT and mem_en SHALL drop.
REQ-014 Whenever data_valid=0, data_out SHALL be 32'h00000013.
REQ-015 flush=1 in IDLE, HOLD or FAULT SHALL cause IDLE next cycle, with data_valid=0 next cycle.
REQ-016 flush=1 in REQ without mem_ack SHALL cause DRAIN. DRAIN SHALL hold mem_en until mem_ack, discard that data, then enter IDLE.
REQ-017 flush=1 coincident with mem_ack in REQ SHALL discard mem_rdata and enter IDLE. flush SHALL have priority over ack.
REQ-018 flush=1 in DRAIN SHALL have no additional effect.
REQ-019 data_valid and fault SHALL be registered outputs. No combinational path SHALL exist from PC_in, stall_in or flush to any output.
REQ-020 The minimum latency SHALL be 3 cycles from PC_in sampled in IDLE to data_valid=1 (IDLE -> REQ with ack -> HOLD).

Reset
REQ-021 reset=0 SHALL asynchronously force the following, regardless of the in-flight access:
- state=IDLE
- mem_en=0, mem_addr=0
- data_valid=0, fault=0
- data_out=32'h00000013
- counter=0
REQ-022 The FSM SHALL leave IDLE no earlier than the first posedge after reset deassertion.

Structure
REQ-023 The state enum, NOP_INSTR (32'h00000013) and the reset PC constant SHALL live in the shared instructions package alongside arch_reg.
REQ-024 Address decode (window check and index) SHALL be one combinational sub-module, imem_addr_decode. The FSM and counter SHALL remain in the top module.

Verification
REQ-025 PC_in=32'h01000000, mem_ack after 2 REQ cycles, mem_rdata=32'hDEADBEEF -> data_valid=1, data_out=32'hDEADBEEF, mem_addr=0.
REQ-026 PC_in=32'h01000002 -> FAULT next cycle, fault=1, data_out=NOP, mem_en never asserted.
REQ-027 PC_in=32'h01004000 with MEM_WORDS=4096 -> fault=1; PC_in=32'h01003FFC -> mem_addr=4095, no fault.
REQ-028 mem_ack withheld for 15 REQ cycles -> fault=1 on the following cycle, mem_en=0.
REQ-029 flush in REQ, ack 3 cycles later with 32'h12345678 -> mem_en held through DRAIN, data_valid stays 0, IDLE after ack.
REQ-030 Two cases:
- stall_in=1 for 5 cycles in HOLD -> data_out constant, data_valid=1.
- reset=0 mid-REQ -> mem_en=0 and data_out=NOP immediately, without a clock edge.
